// File: rtl/player_hand.sv
// player_hand: ordered card hand with play/remove and deck-draw FSM.
// Define HAND_DRAW_TIMEOUT_EN to abort stalled draws after 255 idle cycles.
module player_hand #(
  parameter int HAND_SIZE = 24
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [2:0] i_req_draw,
  input  logic       i_play,
  input  logic [4:0] i_play_idx,
  input  logic [4:0] i_sel_idx,
  output logic [5:0] o_sel_card,
  output logic [2:0] o_draw,
  input  logic       i_deck_done,
  input  logic       i_deck_drawn,
  input  logic [5:0] i_deck_card,
  output logic [5:0] o_played_card,
  output logic       o_play_valid,
  output logic [4:0] o_count,
  output logic       o_full,
  output logic       o_empty,
  output logic       o_busy,
  output logic       o_err
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT_DECK, S_RECV} state_t;
  state_t     r_state, w_next;
  logic [5:0] r_slots [HAND_SIZE];
  logic [5:0] w_up [HAND_SIZE];
  logic [4:0] r_count;
  logic [2:0] r_rem, r_req, w_n;
  logic [5:0] r_played;
  logic       r_pv, r_err;
  logic       w_play, w_err, w_start, w_cap, w_tmo;

  assign w_n = (i_req_draw == 3'b001) ? 3'd1 :
               (i_req_draw == 3'b010) ? 3'd2 :
               (i_req_draw == 3'b100) ? 3'd4 : 3'd0;

  for (genvar g = 0; g < HAND_SIZE; g++) begin : g_up
    if (g < HAND_SIZE - 1) begin : g_mid
      assign w_up[g] = r_slots[g+1];
    end else begin : g_top
      assign w_up[g] = 6'h00;
    end
  end

`ifdef HAND_DRAW_TIMEOUT_EN
  logic [7:0] r_wd;
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || r_state == S_IDLE || w_next != r_state || w_cap) r_wd <= 8'd0;
    else r_wd <= r_wd + 8'd1;
  end
  assign w_tmo = (r_wd == 8'd254);
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next  = r_state;
    w_play  = 1'b0;
    w_err   = 1'b0;
    w_start = 1'b0;
    w_cap   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_play) begin
          w_play = i_play_idx < r_count;
          w_err  = !(i_play_idx < r_count);
        end else if (i_req_draw != 3'b000) begin
          w_start = (w_n != 3'd0) && ({1'b0, r_count} + {3'b000, w_n} <= 6'(HAND_SIZE));
          w_err   = !w_start;
          w_next  = w_start ? S_WAIT_DECK : S_IDLE;
        end
      end
      S_WAIT_DECK: begin
        w_next = i_deck_done ? S_RECV : (w_tmo ? S_IDLE : S_WAIT_DECK);
        w_err  = !i_deck_done && w_tmo;
      end
      S_RECV: begin
        w_cap  = i_deck_drawn;
        w_next = ((i_deck_drawn && r_rem == 3'd1) || (!i_deck_drawn && w_tmo)) ? S_IDLE : S_RECV;
        w_err  = !i_deck_drawn && w_tmo;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    r_state <= !i_rst_n ? S_IDLE : w_next;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count  <= 5'd0;
      r_rem    <= 3'd0;
      r_req    <= 3'd0;
      r_played <= 6'h00;
      r_pv     <= 1'b0;
      r_err    <= 1'b0;
      for (int k = 0; k < HAND_SIZE; k++) r_slots[k] <= 6'h00;
    end else begin
      r_pv  <= w_play;
      r_err <= w_err;
      if (w_play) begin
        r_played <= r_slots[i_play_idx];
        r_count  <= r_count - 5'd1;
      end
      if (w_start) begin
        r_rem <= w_n;
        r_req <= i_req_draw;
      end
      if (w_cap) begin
        r_count <= r_count + 5'd1;
        r_rem   <= r_rem - 3'd1;
      end
      // slots above the played index close the gap; a capture appends at r_count
      for (int k = 0; k < HAND_SIZE; k++) begin
        if (w_play && 5'(k) >= i_play_idx && 5'(k) < r_count) r_slots[k] <= w_up[k];
        if (w_cap && 5'(k) == r_count) r_slots[k] <= i_deck_card;
      end
    end
  end

  assign o_sel_card    = (i_sel_idx < r_count) ? r_slots[i_sel_idx] : 6'h00;
  assign o_draw        = (r_state == S_RECV) ? r_req : 3'b000;
  assign o_played_card = r_played;
  assign o_play_valid  = r_pv;
  assign o_err         = r_err;
  assign o_count       = r_count;
  assign o_full        = r_count == 5'(HAND_SIZE);
  assign o_empty       = r_count == 5'd0;
  assign o_busy        = r_state != S_IDLE;
endmodule

// File: doc/player_hand.md
PLAYER_HAND -- requirements
Module: player_hand

Interface
REQ-001 SHALL have parameter: HAND_SIZE, 24, max cards held (range 4..31).
REQ-002 SHALL have port: i_clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: i_rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: i_req_draw  input  3  controller draw request (001 one, 010 two, 100 four).
REQ-005 SHALL have port: i_play  input  1  controller request to remove card at i_play_idx.
REQ-006 SHALL have port: i_play_idx  input  5  slot index to play.
REQ-007 SHALL have port: i_sel_idx  input  5  slot index for read-back.
REQ-008 SHALL have port: o_sel_card  output  6  card in slot i_sel_idx (combinational); 6'h00 if index >= count.
REQ-009 SHALL have port: o_draw  output  3  draw request to deck, same encoding as i_req_draw.
REQ-010 SHALL have port: i_deck_done  input  1  deck idle/ready.
REQ-011 SHALL have port: i_deck_drawn  input  1  deck presents a valid card this cycle.
REQ-012 SHALL have port: i_deck_card  input  6  card from deck ({color[1:0], value[3:0]}).
REQ-013 SHALL have port: o_played_card  output  6  last played card (registered).
REQ-014 SHALL have port: o_play_valid  output  1  one-cycle pulse; o_played_card updated.
REQ-015 SHALL have ports: o_count (5, cards held), o_full (count==HAND_SIZE), o_empty (count==0), o_busy (state != S_IDLE), o_err (one-cycle error pulse); all outputs.

Function
REQ-016 SHALL implement FSM states S_IDLE, S_WAIT_DECK, S_RECV.
REQ-017 In S_IDLE, when i_play=1, SHALL take priority over i_req_draw. A draw request presented in the same cycle is ignored (no error).
REQ-018 A play with i_play_idx < count SHALL, on the next edge: set o_played_card to the played slot; pulse o_play_valid; shift slots idx+1..count-1 down by one; decrement count.
REQ-019 A play with i_play_idx >= count (including an empty hand) SHALL pulse o_err and change no state.
REQ-020 A non-one-hot, nonzero i_req_draw in S_IDLE SHALL pulse o_err and be ignored.
REQ-021 A draw of N cards where count+N > HAND_SIZE SHALL pulse o_err and be ignored; o_draw stays 000.
REQ-022 A valid draw SHALL latch N into a remaining counter and go to S_WAIT_DECK.
REQ-023 In S_WAIT_DECK, o_draw SHALL be 000; on i_deck_done=1 the FSM SHALL go to S_RECV.
REQ-024 In S_RECV, o_draw SHALL equal the latched one-hot request from the first S_RECV cycle.
REQ-025 In S_RECV, each cycle with i_deck_drawn=1 SHALL write i_deck_card into slot count, increment count, and decrement remaining.
REQ-026 When the final card is captured, o_draw SHALL be 000 from the next cycle and the FSM SHALL return to S_IDLE.
REQ-027 i_deck_drawn SHALL be ignored outside S_RECV.
REQ-028 i_req_draw and i_play SHALL be ignored while o_busy=1 (no error).
REQ-029 Count arithmetic SHALL never wrap; REQ-021 guarantees no overflow.

Reset
REQ-030 While i_rst_n=0 at a clock edge, the block SHALL go to S_IDLE and clear to zero: all slots, count, remaining, o_draw, o_played_card, o_play_valid, o_err. o_empty=1, o_full=0, o_busy=0.
REQ-031 Reset asserted mid-receive SHALL discard all cards, including those already captured; o_draw SHALL be 000 in the cycle after the reset edge.

Configuration
REQ-032 Macro HAND_DRAW_TIMEOUT_EN SHALL enable an 8-bit watchdog in S_WAIT_DECK and S_RECV.
REQ-033 With HAND_DRAW_TIMEOUT_EN, the watchdog SHALL reset on entry to either state and on each captured card. After 255 consecutive cycles with no progress, the block SHALL pulse o_err, drive o_draw=000, keep the cards already captured, and return to S_IDLE.
REQ-034 Without HAND_DRAW_TIMEOUT_EN, the block SHALL wait indefinitely and have no watchdog logic.

Verification
REQ-035 Draw two: reset; i_req_draw=010, i_deck_done=1; i_deck_drawn pulses with 6'h05 then 6'h1C -> o_draw=010 during S_RECV; slot0=05, slot1=1C; o_count=2; o_draw=000 after.
REQ-036 Play middle: hand [05,1C,33]; i_play=1, idx=1 -> o_played_card=1C; o_play_valid for 1 cycle; hand [05,33]; o_count=2.
REQ-037 Invalid play and bad draw: count=3, idx=3 -> o_err pulse, hand unchanged. count=22, HAND_SIZE=24, i_req_draw=100 -> o_err pulse, o_draw stays 000, o_busy=0. i_req_draw=011 -> o_err pulse, ignored.
REQ-038 Simultaneous requests: i_play=1 (idx 0) and i_req_draw=001 in the same S_IDLE cycle -> play executes, no draw, o_err=0.
REQ-039 Reset mid-receive: draw four, 1 card captured, i_rst_n=0 for one edge -> o_count=0, o_empty=1, o_draw=000, FSM in S_IDLE.
REQ-040 Timeout (macro defined): draw one, i_deck_done=1, no i_deck_drawn for 255 cycles -> o_err pulse, o_draw=000, o_count unchanged, o_busy=0.
